mem_seq: RTL and testbench
==========================

Name: mem_seq

Overview:
Block-transfer sequencer that drives the team's synchronous register memory (addr / data_in / wen / data_out, 1-cycle registered read, data_out forced to 0 on write cycles). It takes a command with base address, length and direction, then either streams write beats into memory or reads memory out to a valid/ready stream. It sits between the datapath and the memory so upstream logic never handles memory timing.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_BITS, 5, memory address width; depth = 2**ADDR_BITS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
cmd_write  in  1  1 = write transfer, 0 = read transfer
cmd_base  in  ADDR_BITS  first address
cmd_len  in  ADDR_BITS+1  beat count, 0..2**ADDR_BITS
s_data  in  DATA_WIDTH  write-stream data
s_valid  in  1  write-stream valid
s_ready  out  1  write-stream ready
m_data  out  DATA_WIDTH  read-stream data
m_valid  out  1  read-stream valid
m_ready  in  1  read-stream ready
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  single-cycle completion pulse
mem_addr  out  ADDR_BITS  to memory addr
mem_wdata  out  DATA_WIDTH  to memory data_in
mem_wen  out  1  to memory wen
mem_rdata  in  DATA_WIDTH  from memory data_out

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst. Asserting rst forces every register to reset immediately, mid-transfer included: state=IDLE, count=0, mem_addr=0, mem_wdata=0, mem_wen=0, m_valid=0, s_ready=0, busy=0, done=0. No partial-transfer recovery.
- All outputs are registered, except that m_data = mem_rdata is combinational.
- States: IDLE, WRITE, RD_ADDR, RD_DATA, DONE.
- IDLE, start=1: latch base, len and direction.
  - len=0: go to DONE; no memory access.
  - cmd_write=1: go to WRITE.
  - cmd_write=0: go to RD_ADDR.
  - busy=1 from the next cycle.
  - start while not IDLE is ignored.
- WRITE:
  - s_ready=1.
  - Accept on s_valid&&s_ready: at that edge register mem_wen=1, mem_addr=(base+count) mod 2**ADDR_BITS, mem_wdata=s_data, then count++. The memory commits on the following edge (accept-to-commit = 1 cycle).
  - No accept: mem_wen=0.
  - After the beat with count==len-1 is accepted: s_ready=0, go to DONE. The final mem_wen pulse occurs in the DONE cycle.
- RD_ADDR: mem_wen=0, mem_addr=(base+count) mod depth, m_valid=0; go to RD_DATA.
- RD_DATA:
  - m_valid=1; mem_addr held, so mem_rdata stays stable under backpressure.
  - On m_valid&&m_ready: count++, m_valid=0 next cycle. Go to DONE if this was the last beat, else RD_ADDR.
  - Peak read throughput: 1 beat per 2 cycles. Write throughput: 1 beat per cycle.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE. A start in the DONE cycle is ignored.
- Address wrap: base+count wraps modulo 2**ADDR_BITS (e.g. base 30, len 4 -> 30, 31, 0, 1).
- Max length: len=2**ADDR_BITS touches every address exactly once.
- mem_wen is never high in a read transfer, so mem_rdata is never the write-cycle zero while m_valid=1.

Decomposition:
- Shared package: the state encoding (5 states, localparams), and DATA_WIDTH / ADDR_BITS defaults, shared with the memory's parameters.
- No sub-module needed. The address counter is an inline counter with an explicit mod-depth wrap; split it out only if a second client appears.

Test Plan:
- Write then read back (base 4, len 3, data 0xA1, 0xB2, 0xC3, m_ready=1) -> memory addresses 4..6 hold A1/B2/C3; m_data sequence A1, B2, C3; each done pulse is 1 cycle.
- Wrap-around (write base 30, len 4, data 1..4) -> mem[30]=1, mem[31]=2, mem[0]=3, mem[1]=4; readback matches.
- Read backpressure (m_ready low 5 cycles in beat 2) -> m_valid stays 1, m_data stable at the beat-2 value, mem_addr unchanged, no beat lost or duplicated.
- Write stalls (s_valid toggling 1,0,0,1,1, len 3) -> exactly 3 mem_wen pulses, each 1 cycle after its accept; no write on idle cycles.
- len=0 and start-while-busy -> done 1 cycle after start with no mem_wen; a second start during a transfer does not alter the count or addresses.
- Reset mid-write (rst after beat 2 of 5) -> mem_wen, busy, s_ready, m_valid and done drop asynchronously; state IDLE; a new command after reset runs normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding and default memory geometry for the block-transfer sequencer
package mem_seq_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_BITS_DEF  = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WRITE   = ST_WRITE,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/mem_seq.sv
// mem_seq: block-transfer sequencer between valid/ready streams and a 1-cycle registered-read memory
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_base,
    input  logic [ADDR_BITS:0]    cmd_len,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_BITS:0] ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic [ADDR_BITS:0]    len_q, len_d;
    logic [ADDR_BITS-1:0]  base_q, base_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_wen_q, mem_wen_d;
    logic                  m_valid_q, m_valid_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_BITS:0]    count_inc;
    logic                  last_beat;
    logic [ADDR_BITS-1:0]  addr_cur;
    logic [ADDR_BITS-1:0]  addr_next;
    logic                  w_acc;
    logic                  r_acc;

    // The address counter keeps one extra bit so a full-depth length is representable;
    // only the low bits feed the address, which gives the mod-depth wrap for free.
    assign count_inc = count_q + ONE;
    assign last_beat = (count_q == len_q - ONE);
    assign addr_cur  = base_q + count_q[ADDR_BITS-1:0];
    assign addr_next = base_q + count_inc[ADDR_BITS-1:0];
    assign w_acc     = (state_q == WRITE) && s_valid && s_ready_q;
    assign r_acc     = (state_q == RD_DATA) && m_valid_q && m_ready;

    // Next-state, counter and memory-port decisions; status outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = cmd_base;
                    len_d   = cmd_len;
                    count_d = '0;
                    state_d = (cmd_len == '0) ? DONE : (cmd_write ? WRITE : RD_ADDR);
                    if (!cmd_write && cmd_len != '0)
                        mem_addr_d = cmd_base;
                end
            end
            WRITE: begin
                if (w_acc) begin
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = addr_cur;
                    mem_wdata_d = s_data;
                    count_d     = count_inc;
                    state_d     = last_beat ? DONE : WRITE;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                if (r_acc) begin
                    count_d = count_inc;
                    state_d = last_beat ? DONE : RD_ADDR;
                    if (!last_beat)
                        mem_addr_d = addr_next;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == WRITE);
        m_valid_d = (state_d == RD_DATA);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            m_valid_q   <= m_valid_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = mem_rdata;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: table-driven command bench with a memory model and write/read scoreboards
module tb_mem_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, cmd_write, s_valid, s_ready, m_valid, m_ready, busy, done, mem_wen;
    logic [4:0] cmd_base, mem_addr;
    logic [5:0] cmd_len;
    logic [7:0] s_data, m_data, mem_wdata, mem_rdata;

    mem_seq #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_write(cmd_write), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Team register memory: registered read, data_out forced to zero on a write cycle.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= 8'h00;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    typedef struct {
        logic        wr;
        logic [4:0]  base;
        logic [5:0]  len;
        logic [31:0] d;
        logic [15:0] vpat;
        logic [15:0] rpat;
        logic        rs;
        int          exp_wen;
        int          exp_beats;
    } cmd_t;

    int         errors = 0, checks = 0;
    int         cyc = 0;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] src_q[$];
    logic [7:0] ref_mem [32];
    logic [4:0] wr_base;
    int         wr_idx, acc_cnt, wen_cnt, beats, done_cnt;
    logic       pv = 0, pr = 0, pdone = 0;
    logic [7:0] pd = 0;
    logic [4:0] pa = 0;
    wr_t        e;
    logic [7:0] rexp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) begin
                wr_q.push_back('{5'(wr_base + wr_idx), s_data, cyc + 1});
                wr_idx++;
                acc_cnt++;
                void'(src_q.pop_front());
            end
            if (mem_wen) begin
                wen_cnt++;
                if (wr_q.size() == 0) fail("unexpected_wen");
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", 32'(mem_wdata), 32'(e.d));
                    chk("wr_cycle", cyc, e.c);
                    ref_mem[e.a] = e.d;
                end
            end
            if (m_valid && m_ready) begin
                beats++;
                if (rd_q.size() == 0) fail("unexpected_beat");
                else begin
                    rexp = rd_q.pop_front();
                    chk("rd_data", 32'(m_data), 32'(rexp));
                end
                chk("rd_no_wen", 32'(mem_wen), 0);
            end
            if (pv && !pr && m_valid) begin
                chk("bp_data", 32'(m_data), 32'(pd));
                chk("bp_addr", 32'(mem_addr), 32'(pa));
            end
            if (done) begin
                done_cnt++;
                chk("done_1cyc", 32'(pdone), 0);
            end
            pv = m_valid; pr = m_ready; pd = m_data; pa = mem_addr; pdone = done;
        end
    end

    task automatic xfer(input cmd_t c);
        bit fin;
        wen_cnt = 0; beats = 0; done_cnt = 0; wr_base = c.base; wr_idx = 0;
        src_q.delete();
        for (int i = 0; i < int'(c.len); i++) begin
            if (c.wr) src_q.push_back(i < 4 ? c.d[31 - 8*i -: 8] : 8'(i*7 + int'(c.base)));
            else      rd_q.push_back(ref_mem[5'(int'(c.base) + i)]);
        end
        @(posedge clk); #1;
        start = 1; cmd_write = c.wr; cmd_base = c.base; cmd_len = c.len;
        @(posedge clk); #1;
        start = 0;
        fin = 0;
        for (int t = 0; t < 200 && !fin; t++) begin
            s_valid = c.wr && c.vpat[t % 16] && src_q.size() > 0;
            s_data  = src_q.size() > 0 ? src_q[0] : 8'h00;
            m_ready = c.rpat[t % 16];
            start   = c.rs && t == 1;
            if (start) begin
                cmd_write = !c.wr; cmd_base = c.base + 5'd9; cmd_len = 6'd1;
            end
            @(negedge clk);
            if (t == 0) chk("busy_after_start", 32'(busy), 1);
            if (done) begin
                fin = 1;
                if (c.len == 0) chk("done_latency_len0", t, 0);
            end
            @(posedge clk); #1;
        end
        s_valid = 0; m_ready = 0; start = 0;
        if (!fin) fail("done_timeout");
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("wen_count", wen_cnt, c.exp_wen);
        chk("beat_count", beats, c.exp_beats);
        chk("done_count", done_cnt, 1);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
    endtask

    cmd_t tbl[11];
    cmd_t c2;

    initial begin
        tbl[0]  = '{1'b1, 5'd7,  6'd32, 32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 32, 0};
        tbl[1]  = '{1'b0, 5'd7,  6'd32, 32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 0, 32};
        tbl[2]  = '{1'b1, 5'd10, 6'd3,  32'h55667700, 16'hFF19, 16'hFFFF, 1'b1, 3, 0};
        tbl[3]  = '{1'b0, 5'd10, 6'd3,  32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 0, 3};
        tbl[4]  = '{1'b1, 5'd4,  6'd3,  32'hA1B2C300, 16'hFFFF, 16'hFFFF, 1'b0, 3, 0};
        tbl[5]  = '{1'b0, 5'd4,  6'd3,  32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 0, 3};
        tbl[6]  = '{1'b0, 5'd4,  6'd3,  32'h0,        16'hFFFF, 16'hFF07, 1'b0, 0, 3};
        tbl[7]  = '{1'b1, 5'd30, 6'd4,  32'h01020304, 16'hFFFF, 16'hFFFF, 1'b0, 4, 0};
        tbl[8]  = '{1'b0, 5'd30, 6'd4,  32'h0,        16'hFFFF, 16'hFFFF, 1'b1, 0, 4};
        tbl[9]  = '{1'b1, 5'd5,  6'd0,  32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 0, 0};
        tbl[10] = '{1'b0, 5'd5,  6'd0,  32'h0,        16'hFFFF, 16'hFFFF, 1'b0, 0, 0};

        rst = 1; start = 0; cmd_write = 0; cmd_base = 0; cmd_len = 0;
        s_valid = 0; s_data = 0; m_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 11; i++) xfer(tbl[i]);

        chk("mem4", 32'(mem[4]), 32'hA1);
        chk("mem5", 32'(mem[5]), 32'hB2);
        chk("mem6", 32'(mem[6]), 32'hC3);
        chk("mem30", 32'(mem[30]), 32'h01);
        chk("mem31", 32'(mem[31]), 32'h02);
        chk("mem0", 32'(mem[0]), 32'h03);
        chk("mem1", 32'(mem[1]), 32'h04);

        // A start presented during the DONE cycle must be ignored.
        wen_cnt = 0;
        @(posedge clk); #1;
        start = 1; cmd_write = 1; cmd_base = 5'd3; cmd_len = 6'd0;
        @(posedge clk); #1;
        cmd_len = 6'd2;
        @(negedge clk);
        chk("done_cycle_done", 32'(done), 1);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("done_start_busy", 32'(busy), 0);
        chk("done_start_sready", 32'(s_ready), 0);
        @(negedge clk);
        chk("done_start_wen", wen_cnt, 0);

        // Asynchronous reset in the middle of a 5-beat write.
        wen_cnt = 0; wr_base = 5'd20; wr_idx = 0; acc_cnt = 0;
        src_q.delete();
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        src_q.push_back(8'h44); src_q.push_back(8'h55);
        @(posedge clk); #1;
        start = 1; cmd_write = 1; cmd_base = 5'd20; cmd_len = 6'd5;
        @(posedge clk); #1;
        start = 0;
        for (int n = 0; n < 20 && acc_cnt < 2; n++) begin
            s_valid = 1; s_data = src_q[0];
            @(negedge clk);
            if (acc_cnt < 2) begin
                @(posedge clk); #1;
            end
        end
        if (acc_cnt < 2) fail("rst_accept_timeout");
        @(posedge clk); #2;
        chk("pre_rst_wen", 32'(mem_wen), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1;
        #1;
        chk("arst_wen", 32'(mem_wen), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sready", 32'(s_ready), 0);
        chk("arst_mvalid", 32'(m_valid), 0);
        chk("arst_done", 32'(done), 0);
        s_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        wr_q.delete(); src_q.delete();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        c2 = '{1'b1, 5'd20, 6'd2, 32'h5A6B0000, 16'hFFFF, 16'hFFFF, 1'b0, 2, 0};
        xfer(c2);
        c2 = '{1'b0, 5'd20, 6'd2, 32'h0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 2};
        xfer(c2);
        chk("post_rst_mem20", 32'(mem[20]), 32'h5A);
        chk("post_rst_mem21", 32'(mem[21]), 32'h6B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
